// File: rtl/as5401_pkg.sv
// as5401_pkg: shared phase constants and nibble type for the 5401 bus responder
package as5401_pkg;
  typedef logic [3:0] nibble_t;
  localparam logic [3:0] PH_FETCH = 4'b0001;
  localparam logic [3:0] PH_FLAG  = 4'b0010;
  localparam logic [3:0] PH_OUT   = 4'b0100;
  localparam logic [3:0] PH_ADV   = 4'b1000;
endpackage

// File: rtl/as5401_nibble_ram.sv
// as5401_nibble_ram: 2^AW x 4 register file, sync write/clear, async read
// Ports: clk, rst (sync clear), we_i/waddr_i/wdata_i write port, raddr_i/rdata_o async read port.
module as5401_nibble_ram
  import as5401_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  nibble_t       wdata_i,
  input  logic [AW-1:0] raddr_i,
  output nibble_t       rdata_o
);
  nibble_t mem_q [2**AW];
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2**AW; k++)
      if (rst) mem_q[k] <= '0;
      else if (we_i && waddr_i == AW'(k)) mem_q[k] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/as5401_bus_responder.sv
// as5401_bus_responder: program counter, shift-loaded MAR and nibble RAM serving the 5401 CPU bus
// Ports: clk, rst (sync, active-high); phase/cpu_data/write_flag/mar_flag/jmp_flag/i_flag from the CPU;
// prog_addr/prog_rdata to the program store; ins_out/din_out to the CPU; mar_out debug; phase_err sticky.
module as5401_bus_responder
  import as5401_pkg::*;
#(
  parameter int PC_W   = 12,
  parameter int MAR_W  = 12,
  parameter int RAM_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       phase,
  input  nibble_t          cpu_data,
  input  logic             write_flag,
  input  logic             mar_flag,
  input  logic             jmp_flag,
  input  logic             i_flag,
  output logic [PC_W-1:0]  prog_addr,
  input  nibble_t          prog_rdata,
  output nibble_t          ins_out,
  output nibble_t          din_out,
  output logic [MAR_W-1:0] mar_out,
  output logic             phase_err
);
  logic [PC_W-1:0]  pc_q, pc_d, jmp_tgt_q, jmp_tgt_d;
  logic [MAR_W-1:0] mar_q, mar_d;
  logic             jmp_pend_q, jmp_pend_d, err_q, err_d;
  logic             flag_ph, adv_ph, one_hot, unused_i;
  // immediate operands just occupy the next program slot, so i_flag never steers sequencing
  assign unused_i = i_flag;
  assign one_hot  = (phase != 4'b0) && ((phase & (phase - 4'd1)) == 4'b0);
  assign flag_ph  = phase == PH_FLAG;
  assign adv_ph   = phase == PH_ADV;
  always_comb begin
    mar_d      = (flag_ph && mar_flag) ? {mar_q[MAR_W-5:0], cpu_data} : mar_q;
    jmp_pend_d = (flag_ph && jmp_flag) ? 1'b1 : adv_ph ? 1'b0 : jmp_pend_q;
    jmp_tgt_d  = (flag_ph && jmp_flag) ? mar_q[PC_W-1:0] : jmp_tgt_q;
    pc_d       = !adv_ph ? pc_q : jmp_pend_q ? jmp_tgt_q : pc_q + 1'b1;
    err_d      = err_q | ~one_hot;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      mar_q      <= '0;
      jmp_pend_q <= 1'b0;
      jmp_tgt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      jmp_pend_q <= jmp_pend_d;
      jmp_tgt_q  <= jmp_tgt_d;
      err_q      <= err_d;
    end
  end
  as5401_nibble_ram #(.AW(RAM_AW)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (flag_ph && write_flag),
    .waddr_i (mar_q[RAM_AW-1:0]),
    .wdata_i (cpu_data),
    .raddr_i (mar_q[RAM_AW-1:0]),
    .rdata_o (din_out)
  );
  assign prog_addr = pc_q;
  assign ins_out   = prog_rdata;
  assign mar_out   = mar_q;
  assign phase_err = err_q;
endmodule

// File: doc/as5401_bus_responder.md
Name: as5401_bus_responder

Overview:
- External memory/sequencer side of the 5401 4-bit CPU bus.
- Consumes the CPU's rotating one-hot phase, the latched WRITE/MAR/JMP/I flags and the 4-bit output nibble.
- Supplies the instruction nibble (insin) from a program counter, and the data nibble (din) from an internal nibble RAM addressed by a shift-loaded memory address register (MAR).
- Sits between the CPU wrapper pins and the program store.

Parameters:
- PC_W, 12, program counter / program address width in bits.
- MAR_W, 12, MAR width; multiple of 4, MAR_W >= PC_W.
- RAM_AW, 4, data RAM address width (2^RAM_AW nibbles); RAM_AW <= MAR_W.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- phase  in  4  CPU clock_state, one-hot, rotates 0001->0010->0100->1000.
- cpu_data  in  4  CPU output nibble (D/RR bus).
- write_flag  in  1  CPU WRITE flag.
- mar_flag  in  1  CPU MAR flag.
- jmp_flag  in  1  CPU JMP flag.
- i_flag  in  1  CPU immediate flag; informational only.
- prog_addr  out  PC_W  program store address (= pc).
- prog_rdata  in  4  program store nibble at prog_addr, combinational.
- ins_out  out  4  instruction nibble to CPU insin (= prog_rdata, passthrough).
- din_out  out  4  data nibble to CPU din (= ram[mar[RAM_AW-1:0]], combinational).
- mar_out  out  MAR_W  current MAR, for debug.
- phase_err  out  1  sticky: phase seen non-one-hot.

Behaviour:
- Reset, while rst=1 on a clock edge:
  - pc=0, mar=0, jmp_pend=0, jmp_tgt=0, phase_err=0.
  - All RAM nibbles=0.
  - Outputs therefore read prog_addr=0, mar_out=0, din_out=0.
  - rst has priority over every other action. A reset mid-cycle discards any pending jump or write.
- Flags are stable during phase 0010; sampling happens only then.
- Phase 0010 rising edge, all actions use the MAR value from before this edge:
  - write_flag=1: ram[mar[RAM_AW-1:0]] <= cpu_data.
  - jmp_flag=1: jmp_pend <= 1, jmp_tgt <= mar[PC_W-1:0].
  - mar_flag=1: mar <= {mar[MAR_W-5:0], cpu_data} (left shift by one nibble; top nibble discarded).
  - Any combination of flags may be set together; each acts independently on the old MAR.
- Phase 1000 rising edge:
  - pc <= jmp_pend ? jmp_tgt : pc+1, modulo 2^PC_W. The wrap from all-ones to 0 is silent.
  - jmp_pend <= 0.
  - The new instruction is valid before the next phase 0001.
- Phases 0001 and 0100: no state change.
- Phase not one-hot (0000 or more than one bit set):
  - No RAM, MAR, PC or jump update in that cycle.
  - phase_err <= 1, held until rst.
- Latency:
  - RAM write visible on din_out the cycle after the 0010 edge.
  - Jump visible on prog_addr the cycle after the 1000 edge of the same instruction cycle.
- i_flag: no effect on sequencing. The immediate operand occupies the next program slot, and pc increments normally.
- MAR bits above RAM_AW are ignored for RAM addressing but retained for jumps.

Decomposition:
- Package as5401_pkg:
  - Phase one-hot constants PH_FETCH=4'b0001, PH_FLAG=4'b0010, PH_OUT=4'b0100, PH_ADV=4'b1000.
  - Nibble typedef.
- Sub-module as5401_nibble_ram:
  - 2^RAM_AW x 4 registers.
  - Synchronous write, synchronous reset-clear, asynchronous read.
- PC, MAR, jump and phase-check logic stay in the top module.

Test Plan:
- Reset then run 3 full phase rotations, no flags -> prog_addr 0->1->2->3, each step at a 1000 edge; din_out=0, phase_err=0.
- MAR load: mar_flag with cpu_data 4'hA, 4'h3, 4'h5 on three successive 0010 phases -> mar_out=12'hA35. Then write_flag with cpu_data=4'h9 -> din_out=4'h9 and ram[5]=9.
- Jump: mar=12'h0F0, jmp_flag at 0010 -> at the 1000 edge prog_addr=12'h0F0 rather than pc+1; the next cycle without a flag gives 12'h0F1.
- Simultaneous flags: mar=12'h002, cpu_data=4'h7 with mar_flag, write_flag and jmp_flag together -> ram[2]=7, jump target 12'h002, mar becomes 12'h027.
- Wrap and reset: pc=12'hFFF, no jump -> pc=0 after 1000. Assert rst in phase 0010 with jmp_flag set -> pc=0, jmp_pend cleared, RAM zeroed.
- Phase error: drive phase=4'b0110 with write_flag=1 -> no RAM write, phase_err=1 and held until rst.
